// File: rtl/sha256_msg_scheduler.sv
// SHA-256 message scheduler: pairs two padded 256-bit lines into a 512-bit block
// and streams the 64 schedule words W[0..63] to the compression core over a
// valid/ready handshake, tagged with round index and first/last-block flags.
module sha256_msg_scheduler #(
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_sched_data_val,
    input  logic [DATA_W-1:0] src_sched_data,
    input  logic              src_sched_data_last,
    output logic              sched_src_rdy,
    output logic              sched_dst_w_val,
    output logic [31:0]       sched_dst_w,
    output logic [5:0]        sched_dst_round,
    output logic              sched_dst_block_first,
    output logic              sched_dst_block_last,
    input  logic              dst_sched_w_rdy,
    output logic              sched_proto_err
);

    typedef enum logic [1:0] {
        FILL_UPPER = 2'd0,
        FILL_LOWER = 2'd1,
        EMIT       = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [5:0]  round_q, round_d;
    logic        first_q, first_d;
    logic        last_q, last_d;
    logic        err_q, err_d;
    logic        fill_s;
    logic        emit_s;

    // Small sigma functions of the schedule recurrence.
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

    // Every output is forced low while rst is asserted, independent of stale state.
    assign fill_s                = ~rst & ((state_q == FILL_UPPER) | (state_q == FILL_LOWER));
    assign emit_s                = ~rst & (state_q == EMIT);
    assign sched_src_rdy         = fill_s;
    assign sched_dst_w_val       = emit_s;
    assign sched_dst_w           = emit_s ? win_q[0] : 32'h0000_0000;
    assign sched_dst_round       = emit_s ? round_q : 6'd0;
    assign sched_dst_block_first = emit_s & first_q;
    assign sched_dst_block_last  = emit_s & last_q;
    assign sched_proto_err       = ~rst & err_q;

    // Next-state logic: fill the 16-word window, then slide it one word per handshake.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        round_d = round_q;
        first_d = first_q;
        last_d  = last_q;
        err_d   = err_q;
        case (state_q)
            FILL_UPPER: begin
                if (src_sched_data_val) begin
                    for (int i = 0; i < 8; i++) begin
                        win_d[i] = src_sched_data[DATA_W-1-32*i -: 32];
                    end
                    // A last flag on an upper half is a padder bug: flag it, treat line as upper.
                    if (src_sched_data_last) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    state_d = FILL_LOWER;
                end else begin
                    state_d = FILL_UPPER;
                end
            end
            FILL_LOWER: begin
                if (src_sched_data_val) begin
                    for (int i = 0; i < 8; i++) begin
                        win_d[8+i] = src_sched_data[DATA_W-1-32*i -: 32];
                    end
                    last_d  = src_sched_data_last;
                    round_d = 6'd0;
                    state_d = EMIT;
                end else begin
                    state_d = FILL_LOWER;
                end
            end
            EMIT: begin
                if (dst_sched_w_rdy) begin
                    // The recurrence runs from t=0; words past W[63] are simply never emitted.
                    for (int i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[15] = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];
                    round_d   = round_q + 6'd1;
                    if (round_q == 6'd63) begin
                        state_d = FILL_UPPER;
                        first_d = last_q;
                        last_d  = 1'b0;
                    end else begin
                        state_d = EMIT;
                    end
                end else begin
                    state_d = EMIT;
                end
            end
            default: begin
                state_d = FILL_UPPER;
            end
        endcase
    end

    // State register with synchronous reset; a reset abandons any block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL_UPPER;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= 32'h0000_0000;
            end
            round_q <= 6'd0;
            first_q <= 1'b1;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            round_q <= round_d;
            first_q <= first_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

endmodule
